// File: rtl/cache_bridge_pkg.sv
// Shared encodings and AXI field helpers for the cache-to-AXI bridge.
package cache_bridge_pkg;

   // Cache request type encodings
   localparam logic [2:0] TYPE_BYTE = 3'b000;
   localparam logic [2:0] TYPE_HALF = 3'b001;
   localparam logic [2:0] TYPE_WORD = 3'b010;
   localparam logic [2:0] TYPE_LINE = 3'b100;

   // Read FSM states
   localparam logic [1:0] R_IDLE = 2'd0;
   localparam logic [1:0] R_AR   = 2'd1;
   localparam logic [1:0] R_DATA = 2'd2;

   // Write FSM states
   localparam logic [1:0] W_IDLE = 2'd0;
   localparam logic [1:0] W_REQ  = 2'd1;
   localparam logic [1:0] W_RESP = 2'd2;

   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [7:0] LINE_LEN   = 8'd3;

   // A line is a 4-beat burst; everything else is a single beat.
   function automatic logic [7:0] axi_len(input logic [2:0] t);
      return (t == TYPE_LINE) ? LINE_LEN : 8'd0;
   endfunction

   // Line beats are full words; uncached size comes straight from the type.
   function automatic logic [2:0] axi_size(input logic [2:0] t);
      return (t == TYPE_LINE) ? 3'd2 : {1'b0, t[1:0]};
   endfunction

   // Line bursts start at the 16-byte line boundary.
   function automatic logic [31:0] axi_addr(input logic [2:0] t, input logic [31:0] a);
      return (t == TYPE_LINE) ? {a[31:4], 4'b0000} : a;
   endfunction

endpackage

// File: rtl/cache_axi_wr_chan.sv
// Write side of the bridge: latches one cache write and drives AW/W/B.
module cache_axi_wr_chan
   import cache_bridge_pkg::*;
#(
   parameter int ID_W  = 4,
   parameter int WR_ID = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            wr_req,
   input  logic [2:0]      wr_type,
   input  logic [31:0]     wr_addr,
   input  logic [3:0]      wr_wstrb,
   input  logic [127:0]    wr_data,
   output logic            wr_rdy,
   output logic [ID_W-1:0] awid,
   output logic [31:0]     awaddr,
   output logic [7:0]      awlen,
   output logic [2:0]      awsize,
   output logic [1:0]      awburst,
   output logic            awvalid,
   input  logic            awready,
   output logic [31:0]     wdata,
   output logic [3:0]      wstrb,
   output logic            wlast,
   output logic            wvalid,
   input  logic            wready,
   output logic            bready,
   input  logic            bvalid,
   output logic            busy_o,
   output logic [27:0]     line_addr_o,
   output logic [1:0]      state_o
);

   // Handshake rule: a transfer happens on a cycle where valid and ready are
   // both high at the rising edge; valid and payload never change before that.

   logic [1:0]   state_q, state_d;
   logic [31:0]  addr_q, addr_d;
   logic [27:0]  line_q, line_d;
   logic [7:0]   len_q, len_d;
   logic [2:0]   size_q, size_d;
   logic [3:0]   strb_q, strb_d;
   logic [127:0] data_q, data_d;
   logic         is_line_q, is_line_d;
   logic [1:0]   cnt_q, cnt_d;
   logic         aw_done_q, aw_done_d;
   logic         w_done_q, w_done_d;

   logic aw_fire, w_fire;

   assign wr_rdy      = ~reset & (state_q == W_IDLE);
   assign awvalid     = (state_q == W_REQ) & ~aw_done_q;
   assign wvalid      = (state_q == W_REQ) & ~w_done_q;
   assign bready      = (state_q == W_RESP);
   assign awid        = ID_W'(WR_ID);
   assign awaddr      = addr_q;
   assign awlen       = len_q;
   assign awsize      = size_q;
   assign awburst     = BURST_INCR;
   assign wdata       = data_q[{cnt_q, 5'd0} +: 32];
   assign wstrb       = strb_q;
   assign wlast       = is_line_q ? (cnt_q == 2'd3) : 1'b1;
   assign aw_fire     = awvalid & awready;
   assign w_fire      = wvalid & wready;
   assign busy_o      = (state_q != W_IDLE);
   assign line_addr_o = line_q;
   assign state_o     = state_q;

   // Next-state logic: accept, then run AW and W independently until both finish.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      line_d    = line_q;
      len_d     = len_q;
      size_d    = size_q;
      strb_d    = strb_q;
      data_d    = data_q;
      is_line_d = is_line_q;
      cnt_d     = cnt_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      case (state_q)
         W_IDLE: begin
            if (wr_req & wr_rdy) begin
               state_d   = W_REQ;
               addr_d    = axi_addr(wr_type, wr_addr);
               line_d    = wr_addr[31:4];
               len_d     = axi_len(wr_type);
               size_d    = axi_size(wr_type);
               strb_d    = (wr_type == TYPE_LINE) ? 4'hF : wr_wstrb;
               data_d    = wr_data;
               is_line_d = (wr_type == TYPE_LINE);
               cnt_d     = 2'd0;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
            end
         end
         W_REQ: begin
            if (aw_fire) aw_done_d = 1'b1;
            if (w_fire) cnt_d = cnt_q + 2'd1;
            if (w_fire & wlast) w_done_d = 1'b1;
            if ((aw_done_q | aw_fire) & (w_done_q | (w_fire & wlast))) state_d = W_RESP;
         end
         W_RESP: begin
            if (bvalid) state_d = W_IDLE;
         end
         default: state_d = W_IDLE;
      endcase
   end

   // State and payload registers; reset abandons any write in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= W_IDLE;
         addr_q    <= '0;
         line_q    <= '0;
         len_q     <= '0;
         size_q    <= '0;
         strb_q    <= '0;
         data_q    <= '0;
         is_line_q <= 1'b0;
         cnt_q     <= '0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         line_q    <= line_d;
         len_q     <= len_d;
         size_q    <= size_d;
         strb_q    <= strb_d;
         data_q    <= data_d;
         is_line_q <= is_line_d;
         cnt_q     <= cnt_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
      end
   end

endmodule

// File: rtl/cache_axi_bridge.sv
// Cache miss interface to AXI4 master: one outstanding read plus one write.
module cache_axi_bridge
   import cache_bridge_pkg::*;
#(
   parameter int ID_W  = 4,
   parameter int RD_ID = 0,
   parameter int WR_ID = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            rd_req,
   input  logic [2:0]      rd_type,
   input  logic [31:0]     rd_addr,
   output logic            rd_rdy,
   output logic            ret_valid,
   output logic [1:0]      ret_last,
   output logic [31:0]     ret_data,
   input  logic            wr_req,
   input  logic [2:0]      wr_type,
   input  logic [31:0]     wr_addr,
   input  logic [3:0]      wr_wstrb,
   input  logic [127:0]    wr_data,
   output logic            wr_rdy,
   output logic [ID_W-1:0] arid,
   output logic [31:0]     araddr,
   output logic [7:0]      arlen,
   output logic [2:0]      arsize,
   output logic [1:0]      arburst,
   output logic            arvalid,
   input  logic            arready,
   input  logic [ID_W-1:0] rid,
   input  logic [31:0]     rdata,
   input  logic [1:0]      rresp,
   input  logic            rlast,
   input  logic            rvalid,
   output logic            rready,
   output logic [ID_W-1:0] awid,
   output logic [31:0]     awaddr,
   output logic [7:0]      awlen,
   output logic [2:0]      awsize,
   output logic [1:0]      awburst,
   output logic            awvalid,
   input  logic            awready,
   output logic [31:0]     wdata,
   output logic [3:0]      wstrb,
   output logic            wlast,
   output logic            wvalid,
   input  logic            wready,
   input  logic [ID_W-1:0] bid,
   input  logic [1:0]      bresp,
   input  logic            bvalid,
   output logic            bready
);

   // Handshake rule: a transfer happens on a cycle where valid and ready are
   // both high at the rising edge; valid and payload never change before that.

   logic [1:0]  r_state_q, r_state_d;
   logic [31:0] araddr_q, araddr_d;
   logic [7:0]  arlen_q, arlen_d;
   logic [2:0]  arsize_q, arsize_d;
   logic        wr_busy;
   logic [27:0] wr_line;
   logic [1:0]  w_state;
   logic        raw_block;
   logic        unused_ok;

   // IDs and responses are fixed/ignored by design.
   assign unused_ok = ^{rid, rresp, bid, bresp, w_state};

   // Hold off a read of a line whose writeback is pending or being accepted now.
   assign raw_block = (wr_busy & (rd_addr[31:4] == wr_line)) |
                      (wr_req & wr_rdy & (rd_addr[31:4] == wr_addr[31:4]));

   assign rd_rdy    = ~reset & (r_state_q == R_IDLE) & ~raw_block;
   assign arvalid   = (r_state_q == R_AR);
   assign rready    = (r_state_q == R_DATA);
   assign ret_valid = rready & rvalid;
   assign ret_data  = rdata;
   assign ret_last  = {1'b0, rready & rvalid & rlast};
   assign arid      = ID_W'(RD_ID);
   assign araddr    = araddr_q;
   assign arlen     = arlen_q;
   assign arsize    = arsize_q;
   assign arburst   = BURST_INCR;

   // Read FSM next state: accept, issue AR, stream R until rlast.
   always_comb begin
      r_state_d = r_state_q;
      araddr_d  = araddr_q;
      arlen_d   = arlen_q;
      arsize_d  = arsize_q;
      case (r_state_q)
         R_IDLE: begin
            if (rd_req & rd_rdy) begin
               r_state_d = R_AR;
               araddr_d  = axi_addr(rd_type, rd_addr);
               arlen_d   = axi_len(rd_type);
               arsize_d  = axi_size(rd_type);
            end
         end
         R_AR:    if (arready) r_state_d = R_DATA;
         R_DATA:  if (rvalid & rlast) r_state_d = R_IDLE;
         default: r_state_d = R_IDLE;
      endcase
   end

   // Read state and AR payload registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state_q <= R_IDLE;
         araddr_q  <= '0;
         arlen_q   <= '0;
         arsize_q  <= '0;
      end else begin
         r_state_q <= r_state_d;
         araddr_q  <= araddr_d;
         arlen_q   <= arlen_d;
         arsize_q  <= arsize_d;
      end
   end

   cache_axi_wr_chan #(.ID_W(ID_W), .WR_ID(WR_ID)) u_wr (
      .clk         (clk),
      .reset       (reset),
      .wr_req      (wr_req),
      .wr_type     (wr_type),
      .wr_addr     (wr_addr),
      .wr_wstrb    (wr_wstrb),
      .wr_data     (wr_data),
      .wr_rdy      (wr_rdy),
      .awid        (awid),
      .awaddr      (awaddr),
      .awlen       (awlen),
      .awsize      (awsize),
      .awburst     (awburst),
      .awvalid     (awvalid),
      .awready     (awready),
      .wdata       (wdata),
      .wstrb       (wstrb),
      .wlast       (wlast),
      .wvalid      (wvalid),
      .wready      (wready),
      .bready      (bready),
      .bvalid      (bvalid),
      .busy_o      (wr_busy),
      .line_addr_o (wr_line),
      .state_o     (w_state)
   );

endmodule

// File: doc/cache_axi_bridge.md
Name: cache_axi_bridge

Overview:
- Responder for the cache's miss interface: accepts `rd_req`/`wr_req` from one cache and returns refill data (`ret_valid`/`ret_last`/`ret_data`) and readiness (`rd_rdy`/`wr_rdy`).
- Converts each request into a single AXI4 master transaction: a 4-beat INCR burst for a cache line, one beat for an uncached access.
- Sits between the cache and the SoC AXI interconnect. One read and one write may be outstanding at the same time.

Parameters:
- ID_W, 4, AXI ID width
- RD_ID, 0, constant arid
- WR_ID, 1, constant awid

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- rd_req  in  1  cache read request
- rd_type  in  3  3'b000 byte, 3'b001 half, 3'b010 word, 3'b100 line
- rd_addr  in  32  read address
- rd_rdy  out  1  read request accepted this cycle when rd_req&rd_rdy
- ret_valid  out  1  refill word valid
- ret_last  out  2  bit0 = last beat; bit1 tied 0
- ret_data  out  32  refill word
- wr_req  in  1  cache write request
- wr_type  in  3  same encoding as rd_type
- wr_addr  in  32  write address
- wr_wstrb  in  4  byte strobe (non-line writes only)
- wr_data  in  128  line data, word0 in [31:0]
- wr_rdy  out  1  write request accepted when wr_req&wr_rdy
- arid/araddr/arlen/arsize/arburst  out  ID_W/32/8/3/2  AR payload
- arvalid  out  1; arready  in  1
- rid  in  ID_W; rdata  in  32; rresp  in  2; rlast  in  1; rvalid  in  1; rready  out  1
- awid/awaddr/awlen/awsize/awburst  out  ID_W/32/8/3/2  AW payload
- awvalid  out  1; awready  in  1
- wdata  out  32; wstrb  out  4; wlast  out  1; wvalid  out  1; wready  in  1
- bid  in  ID_W; bresp  in  2; bvalid  in  1; bready  out  1

Behaviour:
- Reset: both FSMs go to IDLE.
  - While reset is high: every valid/ready output is 0, including rd_rdy and wr_rdy.
  - Payload registers clear to 0.
  - An assertion mid-transaction abandons it: no ret_valid and no further AXI beats.
- Length/size mapping:
  - line → len=3, size=2, burst=INCR, address aligned to {addr[31:4],4'b0}.
  - other types → len=0, size=type[1:0], burst=INCR, address unmodified.
- Read FSM R_IDLE→R_AR→R_DATA→R_IDLE.
  - rd_rdy = (state==R_IDLE) & ~raw_block.
  - On acceptance, latch the AR payload; arvalid rises the next cycle and holds stable until arready.
  - R_AR→R_DATA on arready.
  - In R_DATA, rready=1 and the R channel passes through combinationally: ret_valid=rvalid, ret_data=rdata, ret_last={1'b0,rlast}.
  - R_DATA→R_IDLE on rvalid&rlast. The next rd_req can be accepted in the following cycle.
  - rresp is ignored; data is forwarded regardless.
- Write FSM W_IDLE→W_REQ→W_RESP→W_IDLE.
  - wr_rdy = (state==W_IDLE).
  - On acceptance, latch address, type, strobe and 128-bit data, and clear the 2-bit beat counter.
  - W_REQ drives awvalid and wvalid concurrently, tracked by independent aw_done/w_done flags. awvalid drops after the awready handshake.
  - Beat k sends wdata=line word k.
  - wstrb=4'hF for line writes, wr_wstrb for others.
  - wlast=1 on beat 3 for a line, on beat 0 otherwise.
  - Counter increments on wvalid&wready and wraps 3→0.
  - W_REQ→W_RESP when aw_done and the last W beat have both handshaked, including in the same cycle.
  - W_RESP drives bready=1 and returns to W_IDLE on bvalid. bresp is ignored.
- raw_block: asserted while the write FSM is not W_IDLE and rd_addr[31:4]==latched write addr[31:4].
  - This stalls a read of a line whose writeback is not yet acknowledged.
  - Same-cycle rd_req+wr_req: the write is accepted; the read is accepted the same cycle only if its line differs.
- AXI stability: payload and valid are held until the handshake; no valid is ever dropped without a handshake.
- Reads and writes are fully independent; no ordering is imposed other than raw_block.

Decomposition:
- Package cache_bridge_pkg holds:
  - type encodings TYPE_BYTE, TYPE_HALF, TYPE_WORD, TYPE_LINE;
  - read and write state encodings;
  - BURST_INCR;
  - LINE_LEN=8'd3.
- Natural sub-module: cache_axi_wr_chan, containing the write FSM, beat counter and AW/W/B logic.
- The read path stays in the top module.

Test Plan:
- Line refill:
  - Stimulus: rd_req, type=100, addr=0x1C00_0014; slave returns 0xA0,0xA1,0xA2,0xA3.
  - Response: araddr=0x1C00_0010, arlen=3, arsize=2; ret_valid on 4 cycles with data 0xA0..0xA3; ret_last=2'b01 only on 0xA3; rd_rdy back to 1 the next cycle.
- Uncached byte read:
  - Stimulus: type=000, addr=0xBFAF_F003.
  - Response: araddr unchanged, arlen=0, arsize=0; single ret_valid with ret_last=1.
- Line writeback under stalls:
  - Stimulus: wr_data=128'h3333_3333_2222_2222_1111_1111_0000_0000; awready delayed 3 cycles; wready toggling.
  - Response: W beats 0x0000_0000..0x3333_3333 in order, wstrb=F, wlast on beat 3 only; bready asserted; wr_rdy=1 only after bvalid.
- Concurrent requests, different lines:
  - Stimulus: same-cycle wr_req addr 0x0000_1000 and rd_req addr 0x0000_2000.
  - Response: both accepted that cycle; arvalid and awvalid both high the next cycle.
- Same-line hazard:
  - Stimulus: wr_req 0x0000_1000 accepted, then rd_req 0x0000_100C.
  - Response: rd_rdy=0 until the cycle after bvalid; then accepted with araddr=0x0000_1000.
- Reset mid-burst:
  - Stimulus: assert reset after 2 refill beats.
  - Response: all valid outputs 0 immediately; after release rd_rdy=1, wr_rdy=1, no spurious ret_valid.
